vga_frame_regs: RTL and testbench
=================================

# vga_frame_regs

Frame-synchronous register bank that sits directly upstream of the `vgamult` display stage and drives its `dataa`/`datab`/`datac` inputs. The MMU writes three 32-bit shadow registers and arms a commit; the block copies all three to the active outputs in one cycle at the next vertical-sync boundary, so the display never shows a torn, half-updated set. It runs in the VGA pixel clock domain and resynchronises `vsync` internally.

## Interface
- `DATA_W`, 32, width of each data register
- `SYNC_STAGES`, 2, flops in the vsync synchroniser (min 2)
- `VSYNC_ACTIVE_LOW`, 1, 1: frame boundary = vsync high→low; 0: low→high
- `FCNT_W`, 16, frame counter width

- `clk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write strobe, accepted only when `wr_ready`=1
- `wr_addr`  in  2  0/1/2 = shadow A/B/C, 3 = control
- `wr_data`  in  DATA_W  write data; control: bit0 = arm commit
- `wr_ready`  out  1  write accepted this cycle when high
- `vsync`  in  1  raw vertical sync from the timing generator
- `data_a`, `data_b`, `data_c`  out  DATA_W  active registers to the display stage
- `pending`  out  1  commit armed, waiting for frame boundary
- `frame_cnt`  out  FCNT_W  frame boundaries seen since reset

## Operation
- FSM states: IDLE, ARMED, COMMIT.
- IDLE: `wr_ready`=1. Write to addr 0–2 updates that shadow register. Write to addr 3 with bit0=1 → ARMED; bit0=0 is a no-op.
- ARMED: `pending`=1, `wr_ready`=0; every write is ignored. On a frame boundary → COMMIT.
- COMMIT: `wr_ready`=0; all three active registers load their shadow registers in this one cycle; → IDLE.
- Frame boundary: the synchronised vsync shows the configured edge (last stage vs. a registered copy). `frame_cnt` increments on every boundary regardless of state and wraps to 0 from all-ones.
- Arm write in IDLE in the same cycle as a boundary: the state becomes ARMED and that boundary is not used; the commit happens at the next boundary.
- Shadow registers hold their values after a commit; re-arming without new writes recommits the same values.
- Reset (any state, including ARMED/COMMIT): state IDLE; shadow, active, sync flops, `frame_cnt` = 0; `pending`=0; `wr_ready`=1 from the first cycle after reset is sampled. An armed commit is discarded.

## Timing
- Shadow write: visible internally at the next edge; no output change until commit.
- Raw vsync edge first sampled at edge k: boundary detected at edge k+SYNC_STAGES; state=COMMIT and `frame_cnt` updated at that edge; `data_*` change at edge k+SYNC_STAGES+1; `wr_ready` returns high in the same cycle.
- `pending` rises the edge after the arm write and falls when COMMIT is entered.
- All outputs are registered or decoded from state only; there is no combinational path from `wr_*` to any output.

## Configuration
- `VGA_TEST_PATTERN_EN`: when defined, the block adds input ports `pat_on` (1) and `pat_cfg` (6). While `pat_on`=1, each output carries a registered walking-byte pattern: `data_a` = 0xFF << (8·`pat_cfg[5:4]`), `data_b` from `[3:2]`, `data_c` from `[1:0]` (DATA_W=32). The pattern appears one cycle after the inputs and bypasses the frame commit. The active registers keep updating underneath and reappear one cycle after `pat_on` falls. When the macro is undefined, these ports and this logic do not exist.

## Test plan
- Reset: assert `rst` for 2 cycles mid-ARMED → `data_*`=0, `pending`=0, `frame_cnt`=0, `wr_ready`=1.
- Write A=0x11, B=0x22, C=0x33, arm, pulse vsync low (SYNC_STAGES=2) → `data_*` stay 0 until 3 edges after the first sampling edge, then all three change in one cycle to 0x11/0x22/0x33.
- While ARMED, write A=0xDEAD → `wr_ready`=0 and the write is ignored; after the commit, `data_a`=0x11.
- Arm in the same cycle as a boundary → no commit at that boundary; the commit happens at the next boundary; `frame_cnt` increments at both boundaries.
- With FCNT_W=4, apply 17 boundaries → `frame_cnt` wraps 15→0 and ends at 1.
- With `VGA_TEST_PATTERN_EN` defined, `pat_on`=1, `pat_cfg`=6'b00_01_11 → `data_a`=0xFF, `data_b`=0xFF00, `data_c`=0xFF000000 one cycle later; after `pat_on`=0, the committed values return.

Source files
------------

// File: rtl/vga_frame_regs.sv
// vga_frame_regs: frame-synchronous register bank feeding the vgamult display stage.
// Three shadow registers are written by the MMU and, once a commit is armed, are
// copied to the active outputs together at the next vertical-sync boundary, so the
// display never sees a half-updated set. Runs entirely in the pixel clock domain.
// Optional feature macro: VGA_TEST_PATTERN_EN adds pat_on/pat_cfg and a registered
// walking-byte test pattern that overrides the outputs without touching the commit path.

module vga_frame_regs #(
    parameter int DATA_W           = 32,
    parameter int SYNC_STAGES      = 2,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int FCNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              vsync,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] data_c,
    output logic              pending,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              pat_on,
    input  logic [5:0]        pat_cfg,
`endif
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   vsync_sync;
    logic                     vsync_prev;
    logic                     vsync_last;
    logic                     boundary;
    logic                     wr_accept;
    logic [DATA_W-1:0]        shadow_a, shadow_b, shadow_c;
    logic [DATA_W-1:0]        active_a, active_b, active_c;

    assign vsync_last = vsync_sync[SYNC_STAGES-1];
    assign boundary   = VSYNC_ACTIVE_LOW ? (vsync_prev & ~vsync_last)
                                         : (~vsync_prev & vsync_last);
    assign wr_accept  = wr_en && (state == IDLE);

    // Resynchronise raw vsync and keep a delayed copy of the last stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_sync <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], vsync};
            vsync_prev <= vsync_last;
        end
    end

    // Count every frame boundary, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (boundary) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    // Shadow registers take MMU writes only while the bank is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_a <= '0;
            shadow_b <= '0;
            shadow_c <= '0;
        end else if (wr_accept) begin
            case (wr_addr)
                2'd0:    shadow_a <= wr_data;
                2'd1:    shadow_b <= wr_data;
                2'd2:    shadow_c <= wr_data;
                default: ;
            endcase
        end
    end

    // Commit FSM with registered handshake outputs; the active set loads in COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            wr_ready <= 1'b1;
            active_a <= '0;
            active_b <= '0;
            active_c <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_accept && (wr_addr == 2'd3) && wr_data[0]) begin
                        state    <= ARMED;
                        pending  <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                ARMED: begin
                    if (boundary) begin
                        state    <= COMMIT;
                        pending  <= 1'b0;
                        wr_ready <= 1'b0;
                    end
                end
                COMMIT: begin
                    active_a <= shadow_a;
                    active_b <= shadow_b;
                    active_c <= shadow_c;
                    state    <= IDLE;
                    pending  <= 1'b0;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    pending  <= 1'b0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic              pat_q;
    logic [DATA_W-1:0] pat_a, pat_b, pat_c;

    function automatic logic [DATA_W-1:0] walk_byte(input logic [1:0] sel);
        logic [DATA_W-1:0] base;
        base = {{(DATA_W-8){1'b0}}, 8'hFF};
        return base << {sel, 3'b000};
    endfunction

    // Register the test pattern so it appears one cycle after pat_on/pat_cfg
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= 1'b0;
            pat_a <= '0;
            pat_b <= '0;
            pat_c <= '0;
        end else begin
            pat_q <= pat_on;
            pat_a <= walk_byte(pat_cfg[5:4]);
            pat_b <= walk_byte(pat_cfg[3:2]);
            pat_c <= walk_byte(pat_cfg[1:0]);
        end
    end

    assign data_a = pat_q ? pat_a : active_a;
    assign data_b = pat_q ? pat_b : active_b;
    assign data_c = pat_q ? pat_c : active_c;
`else
    assign data_a = active_a;
    assign data_b = active_b;
    assign data_c = active_c;
`endif

endmodule

// File: tb/tb_vga_frame_regs.sv
// tb_vga_frame_regs: directed, table-driven bench for vga_frame_regs.
// The DUT is built with FCNT_W=4 so frame counter wrap-around is reachable quickly.
// Pattern checks are compiled only when VGA_TEST_PATTERN_EN is defined.

module tb_vga_frame_regs;

    localparam int DATA_W = 32;
    localparam int FCNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              vsync;
    logic [DATA_W-1:0] data_a, data_b, data_c;
    logic              pending;
    logic [FCNT_W-1:0] frame_cnt;
    logic              pat_on;
    logic [5:0]        pat_cfg;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        bit        en;
        bit [1:0]  addr;
        bit [31:0] data;
        bit        vs;
        bit [31:0] ea;
        bit [31:0] eb;
        bit [31:0] ec;
        bit        ep;
        bit        er;
        bit [3:0]  ef;
    } vec_t;

    vec_t vecs[26];

    vga_frame_regs #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(2),
        .VSYNC_ACTIVE_LOW(1'b1),
        .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .vsync(vsync),
        .data_a(data_a),
        .data_b(data_b),
        .data_c(data_c),
        .pending(pending),
`ifdef VGA_TEST_PATTERN_EN
        .pat_on(pat_on),
        .pat_cfg(pat_cfg),
`endif
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge
    task automatic applyStimulus(input bit en, input bit [1:0] addr, input bit [31:0] data, input bit vs);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        vsync   = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input bit vs);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'h0, vs);
    endtask

    task automatic checkAll(input string tag, input bit [31:0] ea, input bit [31:0] eb,
                            input bit [31:0] ec, input bit ep, input bit er, input bit [3:0] ef);
        checkOutput({tag, "_data_a"}, data_a, ea);
        checkOutput({tag, "_data_b"}, data_b, eb);
        checkOutput({tag, "_data_c"}, data_c, ec);
        checkOutput({tag, "_pending"}, {31'b0, pending}, {31'b0, ep});
        checkOutput({tag, "_wr_ready"}, {31'b0, wr_ready}, {31'b0, er});
        checkOutput({tag, "_frame_cnt"}, {28'b0, frame_cnt}, {28'b0, ef});
    endtask

    // Write three shadows, arm, then drop vsync and watch the commit land
    task automatic doCommit(input bit [31:0] a, input bit [31:0] b, input bit [31:0] c,
                            input bit [31:0] oa, input bit [31:0] ob, input bit [31:0] oc);
        applyStimulus(1'b1, 2'd0, a, 1'b1);
        applyStimulus(1'b1, 2'd1, b, 1'b1);
        applyStimulus(1'b1, 2'd2, c, 1'b1);
        applyStimulus(1'b1, 2'd3, 32'h1, 1'b1);
        checkOutput("commit_pending_set", {31'b0, pending}, 32'h1);
        idleCycles(3, 1'b0);
        checkOutput("commit_data_a_hold", data_a, oa);
        checkOutput("commit_data_b_hold", data_b, ob);
        checkOutput("commit_data_c_hold", data_c, oc);
        idleCycles(1, 1'b0);
        checkOutput("commit_data_a_new", data_a, a);
        checkOutput("commit_data_b_new", data_b, b);
        checkOutput("commit_data_c_new", data_c, c);
        checkOutput("commit_ready_back", {31'b0, wr_ready}, 32'h1);
        idleCycles(3, 1'b1);
    endtask

    initial begin
        // en addr data vs | data_a data_b data_c pending wr_ready frame_cnt
        vecs[0]  = '{0, 0, 32'h0,    1, 32'h0,  32'h0,  32'h0,  0, 1, 0};
        vecs[1]  = '{0, 0, 32'h0,    1, 32'h0,  32'h0,  32'h0,  0, 1, 0};
        vecs[2]  = '{1, 0, 32'h11,   1, 32'h0,  32'h0,  32'h0,  0, 1, 0};
        vecs[3]  = '{1, 1, 32'h22,   1, 32'h0,  32'h0,  32'h0,  0, 1, 0};
        vecs[4]  = '{1, 2, 32'h33,   1, 32'h0,  32'h0,  32'h0,  0, 1, 0};
        vecs[5]  = '{1, 3, 32'h1,    1, 32'h0,  32'h0,  32'h0,  1, 0, 0};
        vecs[6]  = '{1, 0, 32'hDEAD, 0, 32'h0,  32'h0,  32'h0,  1, 0, 0};
        vecs[7]  = '{0, 0, 32'h0,    0, 32'h0,  32'h0,  32'h0,  1, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,    0, 32'h0,  32'h0,  32'h0,  0, 0, 1};
        vecs[9]  = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 0, 1, 1};
        vecs[10] = '{0, 0, 32'h0,    1, 32'h11, 32'h22, 32'h33, 0, 1, 1};
        vecs[11] = '{0, 0, 32'h0,    1, 32'h11, 32'h22, 32'h33, 0, 1, 1};
        vecs[12] = '{1, 0, 32'h44,   1, 32'h11, 32'h22, 32'h33, 0, 1, 1};
        vecs[13] = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 0, 1, 1};
        vecs[14] = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 0, 1, 1};
        vecs[15] = '{1, 3, 32'h1,    0, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[16] = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[17] = '{0, 0, 32'h0,    1, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[18] = '{0, 0, 32'h0,    1, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[19] = '{0, 0, 32'h0,    1, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[20] = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[21] = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 1, 0, 2};
        vecs[22] = '{0, 0, 32'h0,    0, 32'h11, 32'h22, 32'h33, 0, 0, 3};
        vecs[23] = '{0, 0, 32'h0,    0, 32'h44, 32'h22, 32'h33, 0, 1, 3};
        vecs[24] = '{1, 3, 32'h0,    1, 32'h44, 32'h22, 32'h33, 0, 1, 3};
        vecs[25] = '{0, 0, 32'h0,    1, 32'h44, 32'h22, 32'h33, 0, 1, 3};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = '0;
        vsync   = 1'b1;
        pat_on  = 1'b0;
        pat_cfg = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] running %0d table vectors", $size(vecs));
        for (int i = 0; i < $size(vecs); i++) begin
            applyStimulus(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].vs);
            checkAll($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec,
                     vecs[i].ep, vecs[i].er, vecs[i].ef);
        end

        // Reset while armed discards the commit and clears everything
        applyStimulus(1'b1, 2'd3, 32'h1, 1'b1);
        checkOutput("prereset_pending", {31'b0, pending}, 32'h1);
        rst = 1'b1;
        idleCycles(2, 1'b1);
        rst = 1'b0;
        checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd0);
        idleCycles(3, 1'b1);
        checkAll("postreset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd0);

        // Seventeen boundaries wrap the 4-bit frame counter through zero to one
        for (int i = 0; i < 17; i++) begin
            idleCycles(3, 1'b0);
            checkOutput($sformatf("wrap_fcnt_%0d", i), {28'b0, frame_cnt}, 32'((i + 1) % 16));
            idleCycles(3, 1'b1);
        end
        checkOutput("wrap_final", {28'b0, frame_cnt}, 32'h1);

        doCommit(32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'h0, 32'h0, 32'h0);
        // Re-arming without new writes recommits the same values
        doCommit(32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003,
                 32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003);

`ifdef VGA_TEST_PATTERN_EN
        pat_on  = 1'b1;
        pat_cfg = 6'b00_01_11;
        idleCycles(1, 1'b1);
        checkOutput("pat_data_a", data_a, 32'h0000_00FF);
        checkOutput("pat_data_b", data_b, 32'h0000_FF00);
        checkOutput("pat_data_c", data_c, 32'hFF00_0000);
        pat_on = 1'b0;
        idleCycles(1, 1'b1);
        checkOutput("patoff_data_a", data_a, 32'hA1A1_0001);
        checkOutput("patoff_data_b", data_b, 32'hB2B2_0002);
        checkOutput("patoff_data_c", data_c, 32'hC3C3_0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
